// File: rtl/any1_vmem_seq.sv
// any1_vmem_seq: element sequencer for ANY-1 strided/vector memory ops.
// Walks elements 0..vl-1, steps the address generator, and issues one
// req/ack memory transaction per active element.
// Optional feature: define ANY1_VSEQ_MASK_EN to skip masked-off elements
// and pack steps of active elements when the compressed flag is set.
//
// state | meaning
// IDLE  | waiting for start_i
// SCAN  | test termination / mask, load step for the next active element
// CALC  | step_o stable, address generator registers ea
// REQ   | memory request held until mem_ack_i
// DONE  | one-cycle completion pulse
module any1_vmem_seq #(
  parameter int MAXVL = 64,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       store_i,
  input  logic                       cmprs_i,
  input  logic [$clog2(MAXVL):0]     vl_i,
  input  logic [MAXVL-1:0]           mask_i,
  input  logic [AW-1:0]              ea_i,
  output logic [$clog2(MAXVL)-1:0]   step_o,
  output logic                       busy_o,
  output logic                       mem_req_o,
  output logic                       mem_we_o,
  output logic [AW-1:0]              mem_adr_o,
  output logic [$clog2(MAXVL)-1:0]   mem_elem_o,
  input  logic                       mem_ack_i,
  output logic                       done_o
);

  localparam int SW = $clog2(MAXVL);
  localparam int VW = SW + 1;
  localparam logic [VW-1:0] VL_MAX = VW'(MAXVL);

  typedef enum logic [2:0] {IDLE, SCAN, CALC, REQ, DONE} state_t;

  state_t          state, state_nxt;
  logic            store, cmprs;
  logic [VW-1:0]   vl, elem;
  logic [SW-1:0]   cstep;
  logic            active;
  logic            last;

  // elem is one bit wider than a lane index so vl=MAXVL ends without wrapping
  assign last = (elem == vl);

`ifdef ANY1_VSEQ_MASK_EN
  logic [MAXVL-1:0] mask;

  // Latch the element mask at issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          mask <= '0;
    else if (state == IDLE && start_i) mask <= mask_i;
  end

  assign active = mask[elem[SW-1:0]];
`else
  logic unused_mask;
  assign unused_mask = ^mask_i;
  assign active      = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    busy_o    = (state != IDLE);
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_adr_o = '0;
    done_o    = 1'b0;
    case (state)
      IDLE: if (start_i) state_nxt = SCAN;
      SCAN: begin
        if (last)        state_nxt = DONE;
        else if (active) state_nxt = CALC;
      end
      CALC: state_nxt = REQ;
      REQ: begin
        mem_req_o = 1'b1;
        mem_we_o  = store;
        mem_adr_o = ea_i;
        if (mem_ack_i) state_nxt = SCAN;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Op latches, element/compressed-step counters and step/lane outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      store      <= 1'b0;
      cmprs      <= 1'b0;
      vl         <= '0;
      elem       <= '0;
      cstep      <= '0;
      step_o     <= '0;
      mem_elem_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            store <= store_i;
            cmprs <= cmprs_i;
            vl    <= (vl_i > VL_MAX) ? VL_MAX : vl_i;
            elem  <= '0;
            cstep <= '0;
          end
        end
        SCAN: begin
          if (!last) begin
            if (!active) begin
              elem <= elem + VW'(1);
            end else begin
              // cstep tracks elem exactly unless masked elements were skipped
              step_o     <= cmprs ? cstep : elem[SW-1:0];
              mem_elem_o <= elem[SW-1:0];
            end
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            elem  <= elem + VW'(1);
            cstep <= cstep + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
